// File: rtl/tug_field.sv
// Tug-of-war playfield: conditions the two player keys into one-cycle presses
// and moves a one-hot rope marker toward whichever player pulls.
module tug_field #(
  parameter int NUM_LIGHTS  = 9,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_l,
  input  logic                  key_r,
  input  logic                  gamereset,
  output logic [NUM_LIGHTS-1:0] leds,
  output logic                  press_l,
  output logic                  press_r,
  output logic                  end_l,
  output logic                  end_r,
  output logic                  win_l,
  output logic                  win_r
);

  localparam int PW = $clog2(NUM_LIGHTS);
  localparam int HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

  localparam logic [PW-1:0] CTR       = PW'((NUM_LIGHTS - 1) / 2);
  localparam logic [PW-1:0] LAST      = PW'(NUM_LIGHTS - 1);
  localparam logic [PW-1:0] POS_ONE   = PW'(1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic          sync1_l, sync2_l, prev_l;
  logic          sync1_r, sync2_r, prev_r;
  logic [PW-1:0] pos;
  logic [HW-1:0] hold_cnt;

  // Keys are asynchronous: two flops of synchronisation, then a third flop
  // remembers the previous synchronised level for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_l <= 1'b0;
      sync2_l <= 1'b0;
      prev_l  <= 1'b0;
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_l <= key_l;
      sync2_l <= sync1_l;
      prev_l  <= sync2_l;
      sync1_r <= key_r;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign press_l = sync2_l & ~prev_l;
  assign press_r = sync2_r & ~prev_r;

  // Priority: re-centre, then hold-off, then cancel on a tie, then a single
  // pull. A pull at the far end becomes a win instead of a move.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos      <= CTR;
      hold_cnt <= HOLD_INIT;
      win_l    <= 1'b0;
      win_r    <= 1'b0;
    end else begin
      win_l <= 1'b0;
      win_r <= 1'b0;
      if (gamereset) begin
        pos      <= CTR;
        hold_cnt <= HOLD_INIT;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_ONE;
      end else if (press_l && !press_r) begin
        if (pos < LAST) pos <= pos + POS_ONE;
        else            win_l <= 1'b1;
      end else if (press_r && !press_l) begin
        if (pos != '0) pos <= pos - POS_ONE;
        else           win_r <= 1'b1;
      end
    end
  end

  assign leds  = {{(NUM_LIGHTS-1){1'b0}}, 1'b1} << pos;
  assign end_l = (pos == LAST);
  assign end_r = (pos == '0);

endmodule

// File: tb/tb_tug_field.sv
// Scoreboard bench for tug_field: a 9-light/hold-4 instance for the main game
// and a 3-light/no-hold instance for the narrow-field edge case.
module tb_tug_field;

  logic       clk = 1'b0;
  logic       reset, key_l, key_r, gamereset;
  logic [8:0] leds;
  logic       press_l, press_r, end_l, end_r, win_l, win_r;

  logic       s_key_l, s_key_r, s_gamereset;
  logic [2:0] s_leds;
  logic       s_press_l, s_press_r, s_end_l, s_end_r, s_win_l, s_win_r;

  localparam logic [8:0] CENTRE = 9'b000010000;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vec_count = 0;
  int   miss_count = 0;
  int   pr_count = 0;
  bit   count_en = 1'b0;

  tug_field #(.NUM_LIGHTS(9), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .key_l(key_l), .key_r(key_r),
    .gamereset(gamereset), .leds(leds), .press_l(press_l),
    .press_r(press_r), .end_l(end_l), .end_r(end_r),
    .win_l(win_l), .win_r(win_r)
  );

  tug_field #(.NUM_LIGHTS(3), .HOLD_CYCLES(0)) dut_small (
    .clk(clk), .reset(reset), .key_l(s_key_l), .key_r(s_key_r),
    .gamereset(s_gamereset), .leds(s_leds), .press_l(s_press_l),
    .press_r(s_press_r), .end_l(s_end_l), .end_r(s_end_r),
    .win_l(s_win_l), .win_r(s_win_r)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (count_en && press_r) pr_count++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check_output("scoreboard_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check_output(e.tag, obs, e.val);
    end
  endtask

  // Called at a falling edge; the key is sampled by exactly one rising edge,
  // the press shows two falling edges later and the move one edge after that.
  task automatic apply_stimulus(input bit l, input bit r, input bit gr,
                                input bit exp_pl, input bit exp_pr,
                                input logic [8:0] exp_leds,
                                input bit exp_wl, input bit exp_wr);
    push_exp("press_l", 32'(exp_pl));
    push_exp("press_r", 32'(exp_pr));
    push_exp("leds", 32'(exp_leds));
    push_exp("win_l", 32'(exp_wl));
    push_exp("win_r", 32'(exp_wr));
    push_exp("end_l", 32'(exp_leds[8]));
    push_exp("end_r", 32'(exp_leds[0]));
    key_l = l;
    key_r = r;
    @(negedge clk);
    key_l = 1'b0;
    key_r = 1'b0;
    @(negedge clk);
    pop_check(32'(press_l));
    pop_check(32'(press_r));
    gamereset = gr;
    @(negedge clk);
    gamereset = 1'b0;
    pop_check(32'(leds));
    pop_check(32'(win_l));
    pop_check(32'(win_r));
    pop_check(32'(end_l));
    pop_check(32'(end_r));
  endtask

  task automatic small_tap_right(input logic [2:0] exp_leds, input bit exp_wr);
    push_exp("s_press_r", 32'd1);
    push_exp("s_press_l", 32'd0);
    push_exp("s_leds", 32'(exp_leds));
    push_exp("s_win_r", 32'(exp_wr));
    push_exp("s_win_l", 32'd0);
    push_exp("s_end_r", 32'(exp_leds[0]));
    push_exp("s_end_l", 32'(exp_leds[2]));
    s_key_r = 1'b1;
    @(negedge clk);
    s_key_r = 1'b0;
    @(negedge clk);
    pop_check(32'(s_press_r));
    pop_check(32'(s_press_l));
    @(negedge clk);
    pop_check(32'(s_leds));
    pop_check(32'(s_win_r));
    pop_check(32'(s_win_l));
    pop_check(32'(s_end_r));
    pop_check(32'(s_end_l));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed %0d, expected 0", 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    key_l = 1'b0;
    key_r = 1'b0;
    gamereset = 1'b0;
    s_key_l = 1'b0;
    s_key_r = 1'b0;
    s_gamereset = 1'b0;
    repeat (2) @(negedge clk);

    push_exp("rst_leds", 32'(CENTRE));
    push_exp("rst_end_l", 32'd0);
    push_exp("rst_end_r", 32'd0);
    push_exp("rst_press", 32'd0);
    push_exp("rst_win", 32'd0);
    push_exp("rst_s_leds", 32'(3'b010));
    pop_check(32'(leds));
    pop_check(32'(end_l));
    pop_check(32'(end_r));
    pop_check(32'({press_l, press_r}));
    pop_check(32'({win_l, win_r}));
    pop_check(32'(s_leds));

    reset = 1'b1;
    @(negedge clk);
    // Press lands inside the hold window, then one just after it.
    apply_stimulus(1, 0, 0, 1, 0, CENTRE, 0, 0);
    apply_stimulus(1, 0, 0, 1, 0, 9'b000100000, 0, 0);
    apply_stimulus(1, 0, 0, 1, 0, 9'b001000000, 0, 0);
    apply_stimulus(1, 0, 0, 1, 0, 9'b010000000, 0, 0);
    apply_stimulus(1, 0, 0, 1, 0, 9'b100000000, 0, 0);
    apply_stimulus(1, 0, 0, 1, 0, 9'b100000000, 1, 0);
    push_exp("win_l_pulse_end", 32'd0);
    @(negedge clk);
    pop_check(32'(win_l));

    apply_stimulus(0, 1, 0, 0, 1, 9'b010000000, 0, 0);
    #2 reset = 1'b0;
    push_exp("async_leds", 32'(CENTRE));
    push_exp("async_press", 32'd0);
    push_exp("async_win", 32'd0);
    push_exp("async_end_l", 32'd0);
    #1;
    pop_check(32'(leds));
    pop_check(32'({press_l, press_r}));
    pop_check(32'({win_l, win_r}));
    pop_check(32'(end_l));
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);

    apply_stimulus(1, 1, 0, 1, 1, CENTRE, 0, 0);
    push_exp("held_press_count", 32'd1);
    push_exp("held_leds", 32'(9'b000001000));
    count_en = 1'b1;
    key_r = 1'b1;
    repeat (20) @(negedge clk);
    key_r = 1'b0;
    repeat (4) @(negedge clk);
    count_en = 1'b0;
    pop_check(32'(pr_count));
    pop_check(32'(leds));

    apply_stimulus(0, 1, 0, 0, 1, 9'b000000100, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1, 9'b000000010, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1, 9'b000000001, 0, 0);
    // Winning press meets gamereset: re-centre, no win, then hold-off.
    apply_stimulus(0, 1, 1, 0, 1, CENTRE, 0, 0);
    apply_stimulus(1, 0, 0, 1, 0, CENTRE, 0, 0);

    small_tap_right(3'b001, 1'b0);
    small_tap_right(3'b001, 1'b1);
    push_exp("s_win_r_pulse_end", 32'd0);
    @(negedge clk);
    pop_check(32'(s_win_r));

    check_output("scoreboard_leftover", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
